// File: rtl/man_norm_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | man_norm_round: post-add normalize / round-to-nearest-even for FP adder.   |
// | Optional MAN_NORM_LZC_EN: single-cycle leading-zero-count normalization.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module man_norm_round #(
  parameter int MAN_WIDTH = 11,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_WIDTH+3:0] sum_man,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic                 sign_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_WIDTH-1:0] man_out,
  output logic [EXP_WIDTH-1:0] exp_out,
  output logic                 sign_out,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  localparam int c_WW = MAN_WIDTH + 4;
  localparam int c_HB = MAN_WIDTH + 2;
  localparam int c_EW = EXP_WIDTH + 1;
  localparam logic [c_EW-1:0] c_E_ONE = c_EW'(1);
  localparam logic [c_EW-1:0] c_E_MAX = c_EW'((1 << EXP_WIDTH) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_WW-1:0] r_w;
  logic [c_EW-1:0] r_e;

  logic [c_WW-1:0]      w_w_rsh;
  logic [c_WW-1:0]      w_w_norm;
  logic [c_EW-1:0]      w_e_norm;
  logic                 w_norm_done;
  logic [MAN_WIDTH-1:0] w_man;
  logic                 w_g, w_r, w_s, w_inc;
  logic [MAN_WIDTH:0]   w_man_sum;
  logic [MAN_WIDTH-1:0] w_man_rnd;
  logic [c_EW-1:0]      w_e_rnd;

  assign in_ready = (r_state == S_IDLE);

  // Carry-out right shift keeps the dropped bit alive in the sticky position.
  assign w_w_rsh = {1'b0, r_w[c_WW-1:2], r_w[1] | r_w[0]};

`ifdef MAN_NORM_LZC_EN
  localparam int c_LW = $clog2(c_WW);
  localparam int c_SW = (c_LW > c_EW) ? c_LW : c_EW;
  logic [c_SW-1:0] w_lzc, w_lim, w_sh;

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i <= c_HB; i++)
      if (r_w[i]) w_lzc = c_SW'(c_HB - i);
  end

  assign w_lim       = c_SW'(r_e - c_E_ONE);
  assign w_sh        = (w_lzc < w_lim) ? w_lzc : w_lim;
  assign w_w_norm    = r_w << w_sh;
  assign w_e_norm    = r_e - c_EW'(w_sh);
  assign w_norm_done = 1'b1;
`else
  assign w_w_norm    = {r_w[c_WW-2:0], 1'b0};
  assign w_e_norm    = r_e - c_E_ONE;
  assign w_norm_done = w_w_norm[c_HB] || (w_e_norm == c_E_ONE);
`endif

  assign w_man     = r_w[c_HB:3];
  assign w_g       = r_w[2];
  assign w_r       = r_w[1];
  assign w_s       = r_w[0];
  assign w_inc     = w_g & (w_r | w_s | w_man[0]);
  assign w_man_sum = {1'b0, w_man} + {{MAN_WIDTH{1'b0}}, w_inc};
  assign w_man_rnd = w_man_sum[MAN_WIDTH] ? {1'b1, {(MAN_WIDTH-1){1'b0}}}
                                          : w_man_sum[MAN_WIDTH-1:0];
  assign w_e_rnd   = r_e + {{EXP_WIDTH{1'b0}}, w_man_sum[MAN_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_w       <= '0;
      r_e       <= '0;
      out_valid <= 1'b0;
      man_out   <= '0;
      exp_out   <= '0;
      sign_out  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_w      <= sum_man;
            r_e      <= {1'b0, exp_in};
            sign_out <= sign_in;
            r_state  <= S_PRE;
          end
        end
        S_PRE: begin
          if (r_w == '0) begin
            man_out   <= '0;
            exp_out   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_w[c_WW-1]) begin
            r_w     <= w_w_rsh;
            r_e     <= r_e + c_E_ONE;
            r_state <= S_ROUND;
          end else if (!r_w[c_HB] && (r_e > c_E_ONE)) begin
            r_state <= S_NORM;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_NORM: begin
          r_w <= w_w_norm;
          r_e <= w_e_norm;
          if (w_norm_done) r_state <= S_ROUND;
        end
        S_ROUND: begin
          inexact   <= w_g | w_r | w_s;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          if (w_e_rnd >= c_E_MAX) begin
            exp_out  <= '1;
            man_out  <= '0;
            overflow <= 1'b1;
            inexact  <= 1'b1;
          end else if ((w_e_rnd == c_E_ONE) && !w_man_rnd[MAN_WIDTH-1]) begin
            exp_out   <= '0;
            man_out   <= w_man_rnd;
            underflow <= 1'b1;
          end else begin
            exp_out <= w_e_rnd[EXP_WIDTH-1:0];
            man_out <= w_man_rnd;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Result registers settle on entry; valid is raised one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_man_norm_round.sv
`default_nettype none
// Scoreboard bench for man_norm_round: directed vectors, queued expectations,
// independent output monitor with latency and hold-stability checks.
module tb_man_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] sum_man;
  logic [4:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] man_out;
  logic [4:0]  exp_out;
  logic        sign_out;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  man_norm_round #(.MAN_WIDTH(11), .EXP_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_man   (sum_man),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .man_out   (man_out),
    .exp_out   (exp_out),
    .sign_out  (sign_out),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

`ifdef MAN_NORM_LZC_EN
  localparam int L_CANCEL = 4;
  localparam int L_UNF    = 4;
  localparam int L_CLAMP  = 4;
`else
  localparam int L_CANCEL = 13;
  localparam int L_UNF    = 5;
  localparam int L_CLAMP  = 6;
`endif

  typedef struct {
    logic [19:0] res;   // {man, exp, sign, ovf, unf, inx}
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          seen = 0;
  logic [19:0] snap;
  logic [19:0] got;
  exp_t        cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign got = {man_out, exp_out, sign_out, overflow, underflow, inexact};

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        snap = got;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", got);
        end else begin
          cur = sb.pop_front();
          if (got !== cur.res) begin
            n_bad++;
            $display("FAIL result: got man=%h exp=%h s=%b ovf=%b unf=%b inx=%b, want man=%h exp=%h s=%b ovf=%b unf=%b inx=%b",
                     got[19:9], got[8:4], got[3], got[2], got[1], got[0],
                     cur.res[19:9], cur.res[8:4], cur.res[3], cur.res[2], cur.res[1], cur.res[0]);
          end
          n_cmp++;
          if (cyc - cur.acc != cur.lat) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, want %0d", cyc - cur.acc, cur.lat);
          end
        end
      end else begin
        n_cmp++;
        if (got !== snap || in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL hold: got %h in_ready=%b, want %h in_ready=0", got, in_ready, snap);
        end
      end
      if (out_ready) seen = 0;
    end
  end

  task automatic check_reset(input string name);
    logic [20:0] g;
    g = {out_valid, got};
    n_cmp++;
    if (g !== 21'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got outputs=%h in_ready=%b, want 0 and in_ready=1", name, g, in_ready);
    end
  endtask

  task automatic send(input logic [14:0] sm, input logic [4:0] ei, input logic s,
                      input logic [10:0] m, input logic [4:0] eo,
                      input logic ov, input logic un, input logic ix,
                      input int lat, input bit push);
    int   t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, want 1", t);
    end
    sum_man  = sm;
    exp_in   = ei;
    sign_in  = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = {m, eo, s, ov, un, ix};
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; sum_man = '0; exp_in = '0; sign_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    //    sum_man   exp  s   man     exp  ov unf inx lat
    send(15'h2000, 15, 0, 11'h400, 15, 0, 0, 0, 3, 1);        // normalized
    send(15'h7FF8, 15, 1, 11'h400, 17, 0, 0, 1, 3, 1);        // carry + round-up
    send(15'h0008, 20, 0, 11'h400, 10, 0, 0, 0, L_CANCEL, 1); // cancellation
    send(15'h2004, 15, 0, 11'h400, 15, 0, 0, 1, 3, 1);        // tie, even stays
    send(15'h200C, 15, 0, 11'h402, 15, 0, 0, 1, 3, 1);        // tie, odd rounds up
    send(15'h2006, 15, 0, 11'h401, 15, 0, 0, 1, 3, 1);        // above half
    send(15'h6008, 10, 0, 11'h600, 11, 0, 0, 1, 3, 1);        // carry shift makes tie
    send(15'h6009, 10, 1, 11'h601, 11, 0, 0, 1, 3, 1);        // carry shift keeps sticky
    send(15'h6000, 30, 0, 11'h000, 31, 1, 0, 1, 3, 1);        // overflow via carry
    send(15'h3FFC, 30, 0, 11'h000, 31, 1, 0, 1, 3, 1);        // overflow via rounding
    send(15'h0020,  3, 0, 11'h010,  0, 0, 1, 0, L_UNF, 1);    // underflow
    send(15'h0080,  4, 1, 11'h080,  0, 0, 1, 0, L_CLAMP, 1);  // NORM clamped at E=1
    send(15'h1FFC,  1, 0, 11'h400,  1, 0, 0, 1, 3, 1);        // rounds into normal
    send(15'h0000, 12, 1, 11'h000,  0, 0, 0, 0, 2, 1);        // zero

    // Backpressure: hold out_ready low for 5 cycles once the result is up.
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    send(15'h2000, 15, 0, 11'h400, 15, 0, 0, 0, 3, 1);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (!out_valid) begin
      n_bad++;
      $display("FAIL bp_valid: got out_valid=0, want 1");
    end
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset in the middle of normalization discards the word.
    send(15'h0008, 20, 1, 11'h000, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("reset_async");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("reset_release");

    send(15'h200C, 7, 1, 11'h402, 7, 0, 0, 1, 3, 1);          // recovers after reset

    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 500) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (sb.size() != 0 || !in_ready) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size());
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/man_norm_round.md
Name: man_norm_round

Overview:
- Post-add normalization and rounding stage for the FP adder; consumes the raw sum/difference of two aligned mantissas and is the counterpart of the right-shift aligner.
- Register layout is {carry, mantissa, G, R, S}.
- Iteratively normalizes: one right shift on carry-out, or one left shift per cycle on cancellation.
- Then adjusts the exponent, applies round-to-nearest-even, and hands the result downstream with a valid/ready handshake.

Parameters:
MAN_WIDTH, 11, mantissa width including hidden bit
EXP_WIDTH, 5, biased exponent width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept (high only in IDLE)
sum_man  input  MAN_WIDTH+4  {carry, mantissa[MAN_WIDTH-1:0], G, R, S}
exp_in  input  EXP_WIDTH  exponent of larger operand
sign_in  input  1  result sign
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
man_out  output  MAN_WIDTH  rounded mantissa incl. hidden bit
exp_out  output  EXP_WIDTH  result exponent
sign_out  output  1  registered sign_in
overflow  output  1  result is infinity
underflow  output  1  result subnormal or zero from nonzero input
inexact  output  1  any of final G|R|S set before rounding

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0; man_out, exp_out, sign_out, overflow, underflow, inexact all 0; working register W and exponent register E cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load W=sum_man, E=exp_in, sign -> PRE.
- PRE (1 cycle):
  - W==0: man_out=0, exp_out=0, flags 0 -> DONE (skips ROUND).
  - Carry=1: W>>=1, with S |= bit shifted out of S position; E+=1 -> ROUND.
  - Else, if hidden bit (W[MAN_WIDTH+2]) =0 and E>1 -> NORM.
  - Else -> ROUND.
- NORM (1 cycle per shift):
  - W<<=1 with 0 into LSB; E-=1.
  - Exit to ROUND when hidden bit becomes 1 or E reaches 1.
  - Shifting is never allowed to drive E below 1.
- ROUND:
  - inc = G & (R | S | lsb).
  - mantissa += inc; inexact = G|R|S.
  - Mantissa carry-out: mantissa = 1000...0, E+=1.
  - Subnormal case (E==1 and hidden bit 0 after rounding): exp_out=0, underflow=1.
  - E reaching all-ones (E arithmetic done at EXP_WIDTH+1 bits, any E >= 2^EXP_WIDTH-1): exp_out=all-ones, man_out=0, overflow=1, inexact=1.
  - Go to DONE.
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - No new input is accepted until IDLE, so there is no overlap.
- Latency, accept edge to out_valid high:
  - 3 cycles for already-normalized or carry inputs.
  - 3+k cycles for k left shifts.
  - 2 cycles for zero input.
- Reset mid-operation: immediate return to reset values; the in-flight word is discarded.
- in_valid while busy: ignored (in_ready=0); the upstream must hold.

Optional Feature:
- MAN_NORM_LZC_EN defined:
  - NORM uses a combinational leading-zero count on W.
  - Shifts by min(lzc, E-1) in exactly one cycle.
  - Latency is then 4 cycles for any input needing left shift.
- Undefined: iterative 1-bit/cycle NORM as above.
- Final results are bit-identical in both builds.

Test Plan:
- Normalized: sum_man={0,0x400,000}, exp_in=15 -> man_out=0x400, exp_out=15, inexact=0, out_valid 3 cycles after accept.
- Carry plus round-up: sum_man={1,0x7FF,000}, exp_in=15 -> man_out=0x400, exp_out=17, inexact=1.
- Cancellation: sum_man={0,0x001,000}, exp_in=20 -> man_out=0x400, exp_out=10, out_valid 13 cycles after accept (4 with MAN_NORM_LZC_EN).
- Ties-to-even:
  - {0,0x400,100} -> man_out=0x400, inexact=1.
  - {0,0x401,100} -> man_out=0x402.
- Overflow/underflow:
  - {1,0x400,000}, exp_in=30 -> exp_out=31, man_out=0, overflow=1.
  - {0,0x004,000}, exp_in=3 -> exp_out=0, man_out=0x010, underflow=1.
- Zero, backpressure and reset:
  - sum_man=0 -> exp_out=0, man_out=0, out_valid 2 cycles after accept.
  - out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - rst pulse during NORM -> all outputs 0, in_ready=1 next cycle.
